ifu_fetch_ctrl: RTL

Sequencing controller for the IFU fetch FIFO, which has no occupancy tracking and no flush of its own. It issues sequential fetch requests to the I-cache and drives the FIFO's `push`/`pop` strobes. It uses credit counting so the FIFO never overflows or underflows, and presents a valid/ready interface to decode. On a redirect it drains stale FIFO entries and discards in-flight responses one pop at a time, which keeps the FIFO read/write pointers aligned.

---
 rtl/ifu_fetch_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: sequencing controller for the IFU fetch FIFO (a FIFO with no
// occupancy tracking and no flush of its own).
//   - Issues sequential I-cache fetch requests.
//   - Drives the FIFO push/pop strobes and tracks occupancy plus in-flight
//     responses, so the FIFO can never overflow or underflow.
//   - Presents a valid/ready head to decode.
//   - On a redirect, drains stale entries one pop per cycle and discards
//     in-flight responses, which keeps the FIFO pointers aligned.
// Latency: a push in cycle N is visible to decode in N+1. Outputs are
// combinational from registered state plus same-cycle inputs, and there is no
// dec_ready -> icache_req_valid path.
// Optional build macro IFU_FETCH_CTRL_PERF_EN adds a saturating
// decode-starvation counter; without it, perf_starve_cnt reads 0.
// Ports:
//   clk, rst_n (async, active-low)
//   redirect_valid / redirect_pc              : backend redirect
//   icache_req_valid / _pc / _ready           : request channel
//   icache_resp_valid                         : in-order response strobe
//   fifo_push / fifo_pop                      : FIFO strobes
//   dec_valid / dec_ready                     : decode handshake
//   fifo_count                                : registered occupancy
//   perf_starve_cnt                           : starvation counter
module ifu_fetch_ctrl #(
  parameter int          ADDR_WIDTH      = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] PC_RESET        = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  icache_req_valid,
  output logic [31:0]           icache_req_pc,
  input  logic                  icache_req_ready,
  input  logic                  icache_resp_valid,
  output logic                  fifo_push,
  output logic                  fifo_pop,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic [31:0]           perf_starve_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW    = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic [31:0]         pc;
  logic [ADDR_WIDTH:0] count;
  logic [OW-1:0]       outstanding;

  logic          run_act;
  logic          resp_ok;
  logic          accept;
  logic [SW-1:0] inflight_sum;

  // The low two bits of the redirect target are forced to zero.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  // RUN and not being redirected this cycle: the only time fetch and decode flow.
  assign run_act = (state == RUN) && !redirect_valid;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp_ok = icache_resp_valid && (outstanding != '0);

  // FIFO slots already spoken for: stored entries plus responses still to come.
  assign inflight_sum = SW'(count) + SW'(outstanding);

  assign icache_req_valid = run_act && (inflight_sum < SW'(DEPTH)) &&
                            (outstanding < OW'(MAX_OUTSTANDING));
  assign icache_req_pc    = (state == IDLE) ? '0 : pc;
  assign fifo_push        = run_act && resp_ok;
  assign dec_valid        = run_act && (count != '0);
  // In DRAIN, stale entries are popped blindly (dec_valid stays low) so
  // the FIFO read pointer catches up with the write pointer.
  assign fifo_pop         = (dec_valid && dec_ready) ||
                            ((state == DRAIN) && (count != '0));
  assign fifo_count       = count;
  assign accept           = icache_req_valid && icache_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      count       <= '0;
      outstanding <= '0;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (redirect_valid) state <= DRAIN;
        // Leave only once both the FIFO and the response pipe are empty;
        // a further redirect restarts the wait.
        DRAIN:   if (!redirect_valid && (count == '0) && (outstanding == '0))
                   state <= RUN;
        default: state <= IDLE;
      endcase

      if ((state != IDLE) && redirect_valid)
        pc <= {redirect_pc[31:2], 2'b00};
      else if (accept)
        pc <= pc + 32'd4;

      case ({accept, resp_ok})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IFU_FETCH_CTRL_PERF_EN
  logic [31:0] starve_cnt;

  // Decode is asking for work but the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (run_act && dec_ready && (count == '0) && (starve_cnt != 32'hFFFF_FFFF))
      starve_cnt <= starve_cnt + 32'd1;
  end

  assign perf_starve_cnt = starve_cnt;
`else
  assign perf_starve_cnt = '0;
`endif

endmodule
